// File: rtl/reflet_timer.sv
// Memory-mapped prescaled up-counter for the Reflet bus; pulses timer_int
// for one cycle on every wrap, in auto-reload or one-shot mode.
module reflet_timer #(
   parameter int                          wordsize       = 16,
   parameter int                          base_addr_size = 16,
   parameter logic [base_addr_size-1:0]   base_addr      = 16'hFF10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [base_addr_size-1:0]  addr,
   input  logic                       write_en,
   input  logic [wordsize-1:0]        data_in,
   output logic [wordsize-1:0]        data_out,
   output logic                       timer_int
);

   // One extra bit so base_addr+4 cannot wrap at the top of the map.
   localparam logic [base_addr_size:0] addr_lo = {1'b0, base_addr};
   localparam logic [base_addr_size:0] addr_hi = addr_lo + (base_addr_size+1)'(4);

   logic                  run, auto_rl;
   logic [wordsize-1:0]   presc, max_val, count, pcnt;
   logic                  sel, wr;
   logic [1:0]            off;
   logic                  wr_ctrl, wr_presc, wr_max, wr_count;
   logic                  step_en, tick, wrap;

   assign sel = enable && ({1'b0, addr} >= addr_lo) && ({1'b0, addr} < addr_hi);
   assign off = addr[1:0] - base_addr[1:0];
   assign wr  = sel && write_en;

   assign wr_ctrl  = wr && (off == 2'd0);
   assign wr_presc = wr && (off == 2'd1);
   assign wr_max   = wr && (off == 2'd2);
   assign wr_count = wr && (off == 2'd3);

   // A CTRL write clearing RUN, or a PRESC write, suppresses this edge's tick.
   assign step_en = run && !(wr_ctrl && !data_in[0]) && !wr_presc;
   assign tick    = step_en && (pcnt == presc);
   assign wrap    = tick && !wr_count && (count >= max_val);

   always_comb begin
      data_out = '0;
      if (sel) begin
         case (off)
            2'd0:    data_out = {{(wordsize-2){1'b0}}, auto_rl, run};
            2'd1:    data_out = presc;
            2'd2:    data_out = max_val;
            default: data_out = count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run       <= 1'b0;
         auto_rl   <= 1'b0;
         presc     <= '0;
         max_val   <= '0;
         count     <= '0;
         pcnt      <= '0;
         timer_int <= 1'b0;
      end else begin
         timer_int <= wrap;

         if (step_en)
            pcnt <= tick ? '0 : pcnt + 1'b1;

         if (tick && !wr_count) begin
            if (count >= max_val) count <= '0;
            else                  count <= count + 1'b1;
         end

         if (wrap && !auto_rl)
            run <= 1'b0;

         // Bus writes are applied last so they override the tick results.
         if (wr_ctrl) begin
            run     <= data_in[0];
            auto_rl <= data_in[1];
         end
         if (wr_presc) begin
            presc <= data_in;
            pcnt  <= '0;
         end
         if (wr_max)   max_val <= data_in;
         if (wr_count) count   <= data_in;
      end
   end

endmodule

// File: tb/tb_reflet_timer.sv
// Directed bench for reflet_timer: register access, wrap timing, one-shot,
// bus/tick collisions and synchronous reset.
module tb_reflet_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] addr;
   logic        write_en;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        timer_int;

   int n_tests = 0;
   int n_fail  = 0;

   reflet_timer dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .addr      (addr),
      .write_en  (write_en),
      .data_in   (data_in),
      .data_out  (data_out),
      .timer_int (timer_int)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] off, input logic [15:0] d);
      addr     = 16'hFF10 + 16'(off);
      data_in  = d;
      enable   = 1'b1;
      write_en = 1'b1;
      step();
      enable   = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic rd_addr(input logic [15:0] a, input logic en, output logic [15:0] d);
      addr     = a;
      enable   = en;
      write_en = 1'b0;
      #1;
      d        = data_out;
      enable   = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] off, input logic [15:0] exp);
      logic [15:0] d;
      rd_addr(16'hFF10 + 16'(off), 1'b1, d);
      chk(tag, d, exp);
   endtask

   initial begin
      logic [15:0] d;
      reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
      step(); step();
      reset = 1'b0;

      // 1: reset state
      for (int i = 0; i < 4; i++) chk_reg($sformatf("rst_reg%0d", i), 2'(i), 16'h0000);
      chk("rst_int", timer_int, 1'b0);

      // 2: free-running, PRESC=0 MAX=3
      wr(2'd1, 16'd0);
      wr(2'd2, 16'd3);
      wr(2'd0, 16'h0003);
      chk_reg("fr_count_e0", 2'd3, 16'd0);
      chk("fr_int_e0", timer_int, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step();
         chk_reg($sformatf("fr_count_%0d", i), 2'd3, 16'(i % 4));
         chk($sformatf("fr_int_%0d", i), timer_int, (i % 4) == 0);
      end
      rd_addr(16'hFF14, 1'b1, d); chk("oob_hi", d, 16'h0000);
      rd_addr(16'hFF0F, 1'b1, d); chk("oob_lo", d, 16'h0000);
      rd_addr(16'hFF12, 1'b0, d); chk("no_enable", d, 16'h0000);
      chk_reg("ctrl_rd", 2'd0, 16'h0003);
      chk_reg("max_rd", 2'd2, 16'h0003);

      // 3: one-shot, PRESC=2 MAX=1 -> single pulse after 6 edges
      wr(2'd0, 16'h0000);
      wr(2'd3, 16'd0);
      wr(2'd1, 16'd2);
      wr(2'd2, 16'd1);
      wr(2'd0, 16'h0001);
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("os_int_%0d", i), timer_int, i == 6);
         if (i == 3) chk_reg("os_count_3", 2'd3, 16'd1);
      end
      chk_reg("os_ctrl_end", 2'd0, 16'h0000);
      chk_reg("os_count_end", 2'd3, 16'd0);

      // 4: COUNT write beats the tick
      wr(2'd1, 16'd0);
      wr(2'd2, 16'd9);
      wr(2'd3, 16'd0);
      wr(2'd0, 16'h0003);
      repeat (5) step();
      chk_reg("cw_count5", 2'd3, 16'd5);
      wr(2'd3, 16'd9);
      chk_reg("cw_count9", 2'd3, 16'd9);
      chk("cw_noint", timer_int, 1'b0);
      step();
      chk_reg("cw_wrap_count", 2'd3, 16'd0);
      chk("cw_wrap_int", timer_int, 1'b1);

      // 5: MAX lowered below COUNT; tick on the write edge uses old MAX
      repeat (7) step();
      chk_reg("mx_count7", 2'd3, 16'd7);
      chk("mx_int7", timer_int, 1'b0);
      wr(2'd2, 16'd2);
      chk_reg("mx_count8", 2'd3, 16'd8);
      chk("mx_int8", timer_int, 1'b0);
      step();
      chk_reg("mx_wrap_count", 2'd3, 16'd0);
      chk("mx_wrap_int", timer_int, 1'b1);
      step();
      chk_reg("mx_count1", 2'd3, 16'd1);
      wr(2'd0, 16'h0000);
      chk_reg("stop_count", 2'd3, 16'd1);
      repeat (3) step();
      chk_reg("stop_hold", 2'd3, 16'd1);
      chk("stop_int", timer_int, 1'b0);
      wr(2'd0, 16'h0003);
      chk_reg("restart_count", 2'd3, 16'd1);
      step();
      chk_reg("restart_count2", 2'd3, 16'd2);
      step();
      chk_reg("restart_wrap", 2'd3, 16'd0);
      chk("restart_int", timer_int, 1'b1);

      // MAX=0, PRESC=0: interrupt held high
      wr(2'd0, 16'h0000);
      wr(2'd2, 16'd0);
      wr(2'd3, 16'd0);
      wr(2'd0, 16'h0003);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("cont_int_%0d", i), timer_int, 1'b1);
      end

      // 6: reset mid-count with a concurrent CTRL write
      wr(2'd0, 16'h0000);
      wr(2'd3, 16'd5);
      wr(2'd2, 16'd9);
      wr(2'd0, 16'h0003);
      chk_reg("pre_rst_count", 2'd3, 16'd5);
      reset = 1'b1;
      addr = 16'hFF10; data_in = 16'h0003; enable = 1'b1; write_en = 1'b1;
      step();
      reset = 1'b0; enable = 1'b0; write_en = 1'b0;
      for (int i = 0; i < 4; i++) chk_reg($sformatf("rst2_reg%0d", i), 2'(i), 16'h0000);
      chk("rst2_int", timer_int, 1'b0);
      repeat (3) step();
      chk_reg("rst2_count_hold", 2'd3, 16'd0);
      chk("rst2_int_hold", timer_int, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
